// File: rtl/lod_ctrl_pkg.sv
// Shared types for the LOD sharing logic: requester IDs and the in-flight tag
// that follows each operand through the LOD.
package lod_ctrl_pkg;

    localparam int N_REQ_MAX = 8;
    localparam int ID_W      = $clog2(N_REQ_MAX);

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    vld;
        req_id_t id;
    } lod_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping around, returned both one-hot and as an encoded index.
module rr_arbiter
    import lod_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  req_id_t      ptr,
    output logic [N-1:0] grant,
    output req_id_t      idx
);

    logic hit;

    // Search offset k from ptr; requester j sits at offset k when ptr+k
    // equals j directly or after wrapping past N.
    always_comb begin
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!hit && req[j] &&
                    ((int'(ptr) + k == j) || (int'(ptr) + k == j + N))) begin
                    grant[j] = 1'b1;
                    idx      = req_id_t'(j);
                    hit      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lod_share_arbiter.sv
// Shares one leading-one detector among N_REQ requesters: round-robin issue,
// requester tags carried alongside the LOD latency, results routed back.
module lod_share_arbiter
    import lod_ctrl_pkg::*;
#(
    parameter int W       = 32,
    parameter int N_REQ   = 4,
    parameter int LOD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*W-1:0]     req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [$clog2(W)-1:0]   rsp_pos,
    output logic                   rsp_found,
    output logic                   lod_valid_in,
    output logic [W-1:0]           lod_data_in,
    input  logic                   lod_valid_out,
    input  logic [$clog2(W)-1:0]   lod_pos,
    input  logic                   lod_found,
    output logic                   err,
    output logic                   busy
);

    localparam int D = LOD_LAT + 1;

    logic [N_REQ-1:0] grant_raw;
    logic [N_REQ-1:0] grant;
    req_id_t          g_idx;
    req_id_t          ptr;
    logic [W-1:0]     g_data;
    lod_tag_t         tag_q [D];
    lod_tag_t         tail;
    logic [N_REQ-1:0] rsp_onehot;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant_raw),
        .idx   (g_idx)
    );

    // Nothing may be accepted while the pipeline is being flushed.
    assign grant     = rst ? '0 : grant_raw;
    assign req_ready = grant;
    assign tail      = tag_q[D-1];

    always_comb begin
        g_data = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (grant_raw[j]) g_data = req_data[j*W +: W];
        end
    end

    always_comb begin
        rsp_onehot = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (tail.id == req_id_t'(j)) rsp_onehot[j] = 1'b1;
        end
    end

    always_comb begin
        busy = lod_valid_in;
        for (int i = 0; i < D; i++) begin
            busy = busy | tag_q[i].vld;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            lod_valid_in <= 1'b0;
            lod_data_in  <= '0;
            rsp_valid    <= '0;
            rsp_pos      <= '0;
            rsp_found    <= 1'b0;
            err          <= 1'b0;
            for (int i = 0; i < D; i++) tag_q[i] <= '0;
        end else begin
            lod_valid_in <= |grant;
            if (|grant) begin
                lod_data_in <= g_data;
                ptr         <= (g_idx == req_id_t'(N_REQ-1)) ? '0 : g_idx + 1'b1;
            end
            tag_q[0].vld <= |grant;
            tag_q[0].id  <= g_idx;
            for (int i = 1; i < D; i++) tag_q[i] <= tag_q[i-1];
            // A mismatch leaves rsp_valid low because one of the two terms is 0.
            rsp_valid <= (lod_valid_out && tail.vld) ? rsp_onehot : '0;
            if (lod_valid_out) begin
                rsp_pos   <= lod_pos;
                rsp_found <= lod_found;
            end
            if (lod_valid_out != tail.vld) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lod_share_arbiter.sv
// Bench for lod_share_arbiter with a behavioural LOD of fixed latency and a
// response scoreboard keyed on handshake cycle.
module tb_lod_share_arbiter;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int LAT = 1;
    localparam int PW  = $clog2(W);
    localparam int NV  = 22;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     rsp_valid;
    logic [PW-1:0]    rsp_pos;
    logic             rsp_found;
    logic             lod_valid_in;
    logic [W-1:0]     lod_data_in;
    logic             lod_valid_out;
    logic [PW-1:0]    lod_pos;
    logic             lod_found;
    logic             err;
    logic             busy;

    logic             force_vout;
    logic             mon_en;
    int               cyc;
    int               n_checks;
    int               n_pass;

    lod_share_arbiter #(.W(W), .N_REQ(N), .LOD_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_pos       (rsp_pos),
        .rsp_found     (rsp_found),
        .lod_valid_in  (lod_valid_in),
        .lod_data_in   (lod_data_in),
        .lod_valid_out (lod_valid_out),
        .lod_pos       (lod_pos),
        .lod_found     (lod_found),
        .err           (err),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    function automatic logic [PW-1:0] ref_pos(input logic [W-1:0] d);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < W; i++) begin
            if (d[i]) p = PW'(i);
        end
        return p;
    endfunction

    // Behavioural LOD: registered, LAT cycles, flushed by rst (rst_n = ~rst).
    logic          m_v [LAT];
    logic [PW-1:0] m_p [LAT];
    logic          m_f [LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                m_v[i] <= 1'b0;
                m_p[i] <= '0;
                m_f[i] <= 1'b0;
            end
        end else begin
            m_v[0] <= lod_valid_in;
            m_p[0] <= ref_pos(lod_data_in);
            m_f[0] <= |lod_data_in;
            for (int i = 1; i < LAT; i++) begin
                m_v[i] <= m_v[i-1];
                m_p[i] <= m_p[i-1];
                m_f[i] <= m_f[i-1];
            end
        end
    end

    assign lod_valid_out = m_v[LAT-1] | force_vout;
    assign lod_pos       = m_p[LAT-1];
    assign lod_found     = m_f[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           due;
    } exp_t;

    exp_t sb [$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                sb.delete();
            end else begin
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    chk("rsp_valid", 64'(rsp_valid), 64'(1 << sb[0].id));
                    chk("rsp_pos", 64'(rsp_pos), 64'(ref_pos(sb[0].data)));
                    chk("rsp_found", 64'(rsp_found), 64'(|sb[0].data));
                    void'(sb.pop_front());
                end else begin
                    chk("rsp_idle", 64'(rsp_valid), 64'(0));
                end
                for (int j = 0; j < N; j++) begin
                    if (req_valid[j] && req_ready[j]) begin
                        exp_t e;
                        e.id   = j;
                        e.data = req_data[j*W +: W];
                        e.due  = cyc + LAT + 2;
                        sb.push_back(e);
                    end
                end
            end
        end
    end

    task automatic single(input int id, input logic [W-1:0] d,
                          input logic [PW-1:0] exp_pos, input logic exp_found);
        next();
        req_valid = '0;
        req_data  = '0;
        req_valid[id] = 1'b1;
        req_data[id*W +: W] = d;
        @(negedge clk);
        chk("single_ready", 64'(req_ready), 64'(1 << id));
        next();
        req_valid = '0;
        for (int k = 0; k < LAT + 1; k++) begin
            @(negedge clk);
            chk("single_early", 64'(rsp_valid), 64'(0));
            next();
        end
        @(negedge clk);
        chk("single_rsp", 64'(rsp_valid), 64'(1 << id));
        chk("single_pos", 64'(rsp_pos), 64'(exp_pos));
        chk("single_found", 64'(rsp_found), 64'(exp_found));
    endtask

    task automatic idle(input int n);
        next();
        req_valid = '0;
        repeat (n) next();
    endtask

    typedef struct {
        logic [N-1:0]   valid;
        logic [N-1:0]   ready;
        logic [N*W-1:0] data;
    } vec_t;

    // {valid, expected ready}, applied in order; ptr is 3 at the start.
    localparam logic [7:0] VR [NV] = '{
        8'h44, 8'h00, 8'h88,
        8'hF1, 8'hF2, 8'hF4, 8'hF8, 8'hF1, 8'hF2, 8'hF4, 8'hF8,
        8'h31, 8'h32, 8'h31, 8'h11, 8'h11, 8'h54, 8'h51,
        8'hE2, 8'hE4, 8'hE8, 8'hE2
    };

    vec_t vecs [NV];

    initial begin
        logic [7:0]   vr;
        logic [W-1:0] r;

        n_checks   = 0;
        n_pass     = 0;
        force_vout = 1'b0;
        mon_en     = 1'b0;
        req_data   = '0;
        req_valid  = '1;
        rst        = 1'b1;

        for (int i = 0; i < NV; i++) begin
            vr = VR[i];
            vecs[i].valid = vr[7:4];
            vecs[i].ready = vr[3:0];
            for (int j = 0; j < N; j++) begin
                vecs[i].data[j*W +: W] = W'(1) << ((i * 3 + j * 7) % W);
            end
        end

        @(negedge clk);
        chk("ready_in_rst", 64'(req_ready), 64'(0));
        next();
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("rst_lod_valid_in", 64'(lod_valid_in), 64'(0));
        chk("rst_lod_data_in", 64'(lod_data_in), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_pos", 64'(rsp_pos), 64'(0));
        chk("rst_rsp_found", 64'(rsp_found), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        mon_en = 1'b1;

        single(2, 32'h0001_0000, 5'd16, 1'b1);

        for (int i = 0; i < NV; i++) begin
            next();
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vecs[i].ready));
            if (i == 4) chk("busy_streaming", 64'(busy), 64'(1));
        end
        idle(LAT + 4);

        single(1, 32'h0000_0000, 5'd0, 1'b0);
        single(3, 32'h8000_0000, 5'd31, 1'b1);
        idle(LAT + 4);

        // Spurious LOD valid with an empty tag pipeline.
        mon_en = 1'b0;
        @(negedge clk);
        chk("pre_err", 64'(err), 64'(0));
        next();
        force_vout = 1'b1;
        next();
        force_vout = 1'b0;
        @(negedge clk);
        chk("err_set", 64'(err), 64'(1));
        chk("err_no_rsp", 64'(rsp_valid), 64'(0));
        repeat (3) next();
        @(negedge clk);
        chk("err_sticky", 64'(err), 64'(1));
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("err_cleared", 64'(err), 64'(0));
        sb.delete();
        mon_en = 1'b1;

        // Reset with three operations in flight; ptr is 3 when rst hits.
        next();
        req_valid = '1;
        for (int j = 0; j < N; j++) req_data[j*W +: W] = 32'h0000_0F00 << j;
        next();
        next();
        next();
        req_valid = '0;
        rst       = 1'b1;
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rsp_pos", 64'(rsp_pos), 64'(0));
        chk("mid_rsp_found", 64'(rsp_found), 64'(0));
        chk("mid_lod_valid_in", 64'(lod_valid_in), 64'(0));
        chk("mid_lod_data_in", 64'(lod_data_in), 64'(0));
        chk("mid_err", 64'(err), 64'(0));
        chk("mid_busy", 64'(busy), 64'(0));
        repeat (4) next();
        req_valid = '1;
        @(negedge clk);
        chk("post_rst_ready", 64'(req_ready), 64'(1));
        idle(LAT + 4);

        for (int c = 0; c < 200; c++) begin
            next();
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            for (int j = 0; j < N; j++) begin
                r = $urandom;
                r = r >> $urandom_range(0, W - 1);
                if ($urandom_range(0, 7) == 0) r = '0;
                req_data[j*W +: W] = r;
            end
        end
        idle(LAT + 6);
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        chk("rand_err", 64'(err), 64'(0));
        chk("rand_busy", 64'(busy), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at cycle %0d, %0d/%0d checks passed", cyc, n_pass, n_checks);
        $fatal(1);
    end

endmodule
